arbitrated_ram: RTL

Multi-channel, parameterised scratch RAM for the matrix datapath. It replaces the single-address tri-state memory with NUM_CH independent request channels, for example the result, C, A-transpose, B and final-result address streams. A round-robin arbiter grants one access per cycle through a valid/ready handshake. Read data returns registered, one cycle later, tagged with the channel that issued it.

---
 rtl/ram_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/arbitrated_ram.sv | 105 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared constants and helper functions for the arbitrated scratch RAM.
package ram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int NUM_CH_DEF = 5;

  // Widest request vector rr_pick can scan. Narrower vectors are zero-extended.
  localparam int RR_MAX_CH = 32;

  // Bits needed to index n items. Never returns less than 1, so a 1- or
  // 2-entry selector still gets a real signal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  // Round-robin search. Returns the first index set in req[n-1:0], scanning
  // ptr, ptr+1, ... and wrapping modulo n. Returns -1 when nothing is set.
  function automatic int rr_pick(input logic [RR_MAX_CH-1:0] req,
                                 input int n, input int ptr);
    int pick;
    int idx;
    pick = -1;
    idx  = 0;
    for (int k = 0; k < RR_MAX_CH; k++) begin
      if (k < n && pick < 0) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus its index, and the priority pointer.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic            any_d;
  int              pick;

  // Pick the winner. Reset and Enable gate the grant here, so no access can
  // complete in a reset cycle or while disabled.
  always_comb begin
    pick    = -1;
    any_d   = 1'b0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    if (!Reset && Enable) begin
      pick = rr_pick(RR_MAX_CH'(req), NUM_CH, int'(ptr_q));
    end
    if (pick >= 0) begin
      any_d   = 1'b1;
      gnt_idx = CH_W'(pick);
      ptr_d   = (pick == NUM_CH - 1) ? '0 : CH_W'(pick + 1);
    end
  end

  // Decode the index into the one-hot grant.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gnt
    assign gnt[gi] = any_d && (gnt_idx == CH_W'(gi));
  end

  // The pointer moves just past the winner. With no grant it holds.
  always_ff @(posedge Clock) begin
    if (Reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/arbitrated_ram.sv
// Multi-channel scratch RAM. A round-robin arbiter admits one access per
// cycle. Reads return one cycle later, tagged with the requesting channel.
module arbitrated_ram
  import ram_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Enable,
  input  logic [NUM_CH-1:0]        ReqValid,
  input  logic [NUM_CH-1:0]        ReqWrite,
  input  logic [NUM_CH*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_CH*DATA_W-1:0] ReqData,
  output logic [NUM_CH-1:0]        ReqReady,
  output logic                     RspValid,
  output logic [CH_W-1:0]          RspCh,
  output logic [DATA_W-1:0]        RspData,
  output logic                     AddrErr
);

  localparam int              MEM_AW  = clog2_min1(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;

  logic [ADDR_W-1:0] addr_arr [NUM_CH];
  logic [DATA_W-1:0] data_arr [NUM_CH];

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_write;
  logic              xfer;
  logic              in_range;
  logic [MEM_AW-1:0] mem_idx;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rsp_valid_q;
  logic [CH_W-1:0]   rsp_ch_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              addr_err_q;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .req     (ReqValid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ReqReady = gnt;

  // Split the flat request buses into one entry per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign addr_arr[gi] = ReqAddr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = ReqData[gi*DATA_W +: DATA_W];
  end

  // Route the granted channel's request to the memory port.
  always_comb begin
    xfer      = |gnt;
    sel_addr  = addr_arr[gnt_idx];
    sel_data  = data_arr[gnt_idx];
    sel_write = ReqWrite[gnt_idx];
    in_range  = {1'b0, sel_addr} < DEPTH_L;
    mem_idx   = sel_addr[MEM_AW-1:0];
  end

  // The memory has no reset, so its contents survive Reset.
  // Out-of-range writes are dropped.
  always_ff @(posedge Clock) begin
    if (xfer && sel_write && in_range) mem_q[mem_idx] <= sel_data;
  end

  // Registered read response and sticky address error. Reset values win
  // over a response that would otherwise be due.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      rsp_valid_q <= xfer && !sel_write;
      if (xfer && !sel_write) begin
        rsp_ch_q   <= gnt_idx;
        rsp_data_q <= in_range ? mem_q[mem_idx] : '0;
      end
      if (xfer && !in_range) addr_err_q <= 1'b1;
    end
  end

  assign RspValid = rsp_valid_q;
  assign RspCh    = rsp_ch_q;
  assign RspData  = rsp_data_q;
  assign AddrErr  = addr_err_q;

endmodule
